// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave bridging a host master to a bank of 32-bit R/W registers.
// Each write needs AW and W valid together and returns a B response.
// Each read returns its data on R one cycle after the AR handshake.
module axil_reg_bridge #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int unsigned         IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] REG_SPAN  = (ADDR_WIDTH+1)'(4 * NUM_REGS);
    localparam logic [1:0]          RESP_OKAY = 2'b00;
    localparam logic [1:0]          RESP_SLV  = 2'b10;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q,  bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q,  rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

    logic                  wr_hs;
    logic                  rd_hs;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;

    // Address decode: word index from bits above the byte offset, range check on full address
    assign aw_idx      = s_axi_awaddr[IDX_W+1:2];
    assign ar_idx      = s_axi_araddr[IDX_W+1:2];
    assign aw_in_range = {1'b0, s_axi_awaddr} < REG_SPAN;
    assign ar_in_range = {1'b0, s_axi_araddr} < REG_SPAN;

    // Write accepts AW+W as one beat, only when the B slot is free or draining this cycle
    assign s_axi_awready = s_axi_awvalid & s_axi_wvalid & (~bvalid_q | s_axi_bready);
    assign s_axi_wready  = s_axi_awready;
    assign wr_hs         = s_axi_awready;

    // Read address accepted whenever the R slot is free or draining this cycle
    assign s_axi_arready = ~rvalid_q | s_axi_rready;
    assign rd_hs         = s_axi_arvalid & s_axi_arready;

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;

    // Response channel next state; payloads hold while valid is stalled
    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;

        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLV;
        end else if (s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (rd_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLV;
            rdata_d  = ar_in_range ? regs_q[ar_idx] : '0;
        end else if (s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Response channel state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    // Register bank; out-of-range writes leave it untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_hs && aw_in_range) begin
            regs_q[aw_idx] <= s_axi_wdata;
        end
    end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Self-checking bench for axil_reg_bridge: directed scenarios plus a randomized
// run scored against a transaction-level register model.
module tb_axil_reg_bridge;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [7:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [16];

    axil_reg_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [7:0] a);
        return (a < 8'h40) ? model[a[5:2]] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [7:0] a);
        return (a < 8'h40) ? OKAY : SLVERR;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        if (a < 8'h40) model[a[5:2]] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    // Full write transaction with bready held high; returns the response seen after the handshake edge
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             output logic [1:0] resp, output logic bv, output logic ok);
        s_axi_awaddr = a; s_axi_wdata = d;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_axi_awready && s_axi_wready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        resp = s_axi_bresp; bv = s_axi_bvalid;
        @(posedge clk); #1;
    endtask

    // Full read transaction with rready held high
    task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output logic rv, output logic ok);
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_axi_arready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        d = s_axi_rdata; resp = s_axi_rresp; rv = s_axi_rvalid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; logic v, ok;
        model_clear();
        #12;
        checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b exp 0", s_axi_bvalid); end
        checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", s_axi_rvalid); end
        checks++; if (s_axi_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", s_axi_rdata); end
        checks++; if (s_axi_bresp !== OKAY || s_axi_rresp !== OKAY) begin errors++; $display("FAIL reset_resp got b=%b r=%b exp 00", s_axi_bresp, s_axi_rresp); end
        checks++; if (s_axi_arready !== 1'b1) begin errors++; $display("FAIL reset_arready got %b exp 1", s_axi_arready); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        axi_read(8'h00, d, r, v, ok);
        checks++; if (!ok || v !== 1'b1 || d !== 32'h0 || r !== OKAY) begin errors++; $display("FAIL reset_read0 got ok=%b v=%b d=%h r=%b exp 1 1 00000000 00", ok, v, d, r); end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [1:0] r; logic v, ok;
        axi_write(8'h04, 32'hDEADBEEF, r, v, ok);
        model_write(8'h04, 32'hDEADBEEF);
        checks++; if (!ok || v !== 1'b1 || r !== OKAY) begin errors++; $display("FAIL basic_write got ok=%b bvalid=%b bresp=%b exp 1 1 00", ok, v, r); end
        checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL basic_bclear got %b exp 0", s_axi_bvalid); end
        axi_read(8'h04, d, r, v, ok);
        checks++; if (!ok || v !== 1'b1 || d !== 32'hDEADBEEF || r !== OKAY) begin errors++; $display("FAIL basic_read got ok=%b v=%b d=%h r=%b exp 1 1 deadbeef 00", ok, v, d, r); end
        checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL basic_rclear got %b exp 0", s_axi_rvalid); end
    endtask

    task automatic test_all_regs();
        logic [31:0] d; logic [1:0] r; logic v, ok;
        for (int i = 0; i < 16; i++) begin
            axi_write(8'(4 * i), 32'h1000_0000 + 32'(i), r, v, ok);
            model_write(8'(4 * i), 32'h1000_0000 + 32'(i));
            checks++; if (!ok || v !== 1'b1 || r !== OKAY) begin errors++; $display("FAIL allregs_write[%0d] got ok=%b v=%b r=%b", i, ok, v, r); end
        end
        for (int i = 0; i < 16; i++) begin
            axi_read(8'(4 * i), d, r, v, ok);
            checks++; if (!ok || v !== 1'b1 || d !== model_read(8'(4 * i)) || r !== OKAY) begin errors++; $display("FAIL allregs_read[%0d] got d=%h r=%b exp d=%h r=00", i, d, r, model_read(8'(4 * i))); end
        end
        axi_read(8'h05, d, r, v, ok);
        checks++; if (!ok || d !== 32'h1000_0001 || r !== OKAY) begin errors++; $display("FAIL alias_read05 got d=%h r=%b exp 10000001 00", d, r); end
        axi_read(8'h3F, d, r, v, ok);
        checks++; if (!ok || d !== 32'h1000_000F || r !== OKAY) begin errors++; $display("FAIL alias_read3f got d=%h r=%b exp 1000000f 00", d, r); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r; logic v, ok;
        axi_write(8'h40, 32'h12345678, r, v, ok);
        checks++; if (!ok || v !== 1'b1 || r !== SLVERR) begin errors++; $display("FAIL oor_write got ok=%b v=%b r=%b exp 1 1 10", ok, v, r); end
        axi_write(8'hFC, 32'hA5A5A5A5, r, v, ok);
        checks++; if (!ok || r !== SLVERR) begin errors++; $display("FAIL oor_write_fc got r=%b exp 10", r); end
        for (int i = 0; i < 16; i++) begin
            axi_read(8'(4 * i), d, r, v, ok);
            checks++; if (d !== model_read(8'(4 * i)) || r !== OKAY) begin errors++; $display("FAIL oor_nochange[%0d] got %h exp %h", i, d, model_read(8'(4 * i))); end
        end
        axi_read(8'h80, d, r, v, ok);
        checks++; if (!ok || v !== 1'b1 || d !== 32'h0 || r !== SLVERR) begin errors++; $display("FAIL oor_read80 got d=%h r=%b exp 00000000 10", d, r); end
        axi_read(8'h40, d, r, v, ok);
        checks++; if (d !== 32'h0 || r !== SLVERR) begin errors++; $display("FAIL oor_read40 got d=%h r=%b exp 00000000 10", d, r); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [1:0] r; logic v, ok;
        // Write held off by stalled B
        s_axi_awaddr = 8'h08; s_axi_wdata = 32'hCAFE0001;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        @(posedge clk); #1;
        model_write(8'h08, 32'hCAFE0001);
        checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== OKAY) begin errors++; $display("FAIL bp_first got v=%b r=%b exp 1 00", s_axi_bvalid, s_axi_bresp); end
        s_axi_awaddr = 8'h44; s_axi_wdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin errors++; $display("FAIL bp_wblock[%0d] got aw=%b w=%b exp 0 0", i, s_axi_awready, s_axi_wready); end
            @(posedge clk); #1;
            checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== OKAY) begin errors++; $display("FAIL bp_bhold[%0d] got v=%b r=%b exp 1 00", i, s_axi_bvalid, s_axi_bresp); end
        end
        s_axi_bready = 1'b1; #1;
        checks++; if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin errors++; $display("FAIL bp_wrelease got aw=%b w=%b exp 1 1", s_axi_awready, s_axi_wready); end
        @(posedge clk); #1;
        checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== SLVERR) begin errors++; $display("FAIL bp_b2b got v=%b r=%b exp 1 10", s_axi_bvalid, s_axi_bresp); end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL bp_bdrain got %b exp 0", s_axi_bvalid); end
        // Read stalled by R
        s_axi_araddr = 8'h08; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== model_read(8'h08)) begin errors++; $display("FAIL bp_rfirst got v=%b d=%h exp 1 %h", s_axi_rvalid, s_axi_rdata, model_read(8'h08)); end
        s_axi_araddr = 8'h0C;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (s_axi_arready !== 1'b0) begin errors++; $display("FAIL bp_arblock[%0d] got %b exp 0", i, s_axi_arready); end
            @(posedge clk); #1;
            checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== model_read(8'h08) || s_axi_rresp !== OKAY) begin errors++; $display("FAIL bp_rhold[%0d] got v=%b d=%h exp 1 %h", i, s_axi_rvalid, s_axi_rdata, model_read(8'h08)); end
        end
        s_axi_rready = 1'b1; #1;
        checks++; if (s_axi_arready !== 1'b1) begin errors++; $display("FAIL bp_arrelease got %b exp 1", s_axi_arready); end
        @(posedge clk); #1;
        checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== model_read(8'h0C)) begin errors++; $display("FAIL bp_rb2b got v=%b d=%h exp 1 %h", s_axi_rvalid, s_axi_rdata, model_read(8'h0C)); end
        s_axi_arvalid = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL bp_rdrain got %b exp 0", s_axi_rvalid); end
        axi_read(8'h08, d, r, v, ok);
        checks++; if (d !== 32'hCAFE0001) begin errors++; $display("FAIL bp_readback got %h exp cafe0001", d); end
    endtask

    task automatic test_aw_wait();
        logic [31:0] d; logic [1:0] r; logic v, ok;
        s_axi_awaddr = 8'h10; s_axi_wdata = 32'h5A5A1234;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin errors++; $display("FAIL awwait_block[%0d] got aw=%b w=%b exp 0 0", i, s_axi_awready, s_axi_wready); end
            @(posedge clk); #1;
            checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL awwait_nob[%0d] got %b exp 0", i, s_axi_bvalid); end
        end
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        checks++; if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin errors++; $display("FAIL awwait_accept got aw=%b w=%b exp 1 1", s_axi_awready, s_axi_wready); end
        @(posedge clk); #1;
        model_write(8'h10, 32'h5A5A1234);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== OKAY) begin errors++; $display("FAIL awwait_b got v=%b r=%b exp 1 00", s_axi_bvalid, s_axi_bresp); end
        @(posedge clk); #1;
        axi_read(8'h10, d, r, v, ok);
        checks++; if (d !== 32'h5A5A1234) begin errors++; $display("FAIL awwait_readback got %h exp 5a5a1234", d); end
    endtask

    task automatic test_same_cycle_rw();
        logic [31:0] old;
        old = model_read(8'h14);
        s_axi_awaddr = 8'h14; s_axi_wdata = 32'h0BADF00D; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        s_axi_araddr = 8'h14; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        @(posedge clk); #1;
        model_write(8'h14, 32'h0BADF00D);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old) begin errors++; $display("FAIL rw_same_old got v=%b d=%h exp 1 %h", s_axi_rvalid, s_axi_rdata, old); end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        checks++; if (s_axi_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rw_same_new got %h exp 0badf00d", s_axi_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; logic v, ok;
        s_axi_awaddr = 8'h0C; s_axi_wdata = 32'h77778888; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        s_axi_araddr = 8'h00; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        rst = 1'b0; #1;
        model_clear();
        checks++; if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_rdata !== 32'h0) begin errors++; $display("FAIL midreset got bv=%b rv=%b d=%h exp 0 0 0", s_axi_bvalid, s_axi_rvalid, s_axi_rdata); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        axi_read(8'h0C, d, r, v, ok);
        checks++; if (d !== 32'h0 || r !== OKAY) begin errors++; $display("FAIL midreset_reg got %h exp 0", d); end
    endtask

    task automatic test_random();
        logic exp_bv = 1'b0, exp_rv = 1'b0, wr, ar_rdy;
        logic [1:0] exp_br = OKAY, exp_rr = OKAY;
        logic [31:0] exp_rd = 32'h0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            checks++; if (s_axi_bvalid !== exp_bv) begin errors++; $display("FAIL rand_bvalid c=%0d got %b exp %b", c, s_axi_bvalid, exp_bv); end
            if (exp_bv) begin checks++; if (s_axi_bresp !== exp_br) begin errors++; $display("FAIL rand_bresp c=%0d got %b exp %b", c, s_axi_bresp, exp_br); end end
            checks++; if (s_axi_rvalid !== exp_rv) begin errors++; $display("FAIL rand_rvalid c=%0d got %b exp %b", c, s_axi_rvalid, exp_rv); end
            if (exp_rv) begin checks++; if (s_axi_rdata !== exp_rd || s_axi_rresp !== exp_rr) begin errors++; $display("FAIL rand_rdata c=%0d got %h/%b exp %h/%b", c, s_axi_rdata, s_axi_rresp, exp_rd, exp_rr); end end
            s_axi_awaddr  = 8'($urandom_range(0, 95));
            s_axi_wdata   = $urandom;
            s_axi_awvalid = ($urandom_range(0, 3) != 0);
            s_axi_wvalid  = ($urandom_range(0, 3) != 0);
            s_axi_bready  = ($urandom_range(0, 3) != 0);
            s_axi_araddr  = 8'($urandom_range(0, 95));
            s_axi_arvalid = ($urandom_range(0, 2) != 0);
            s_axi_rready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            wr     = s_axi_awvalid && s_axi_wvalid && (!exp_bv || s_axi_bready);
            ar_rdy = !exp_rv || s_axi_rready;
            checks++; if (s_axi_awready !== wr || s_axi_wready !== wr) begin errors++; $display("FAIL rand_wready c=%0d got %b/%b exp %b", c, s_axi_awready, s_axi_wready, wr); end
            checks++; if (s_axi_arready !== ar_rdy) begin errors++; $display("FAIL rand_arready c=%0d got %b exp %b", c, s_axi_arready, ar_rdy); end
            if (s_axi_arvalid && ar_rdy) begin
                exp_rd = model_read(s_axi_araddr); exp_rr = model_resp(s_axi_araddr); exp_rv = 1'b1;
            end else if (s_axi_rready) begin
                exp_rv = 1'b0;
            end
            if (wr) begin
                model_write(s_axi_awaddr, s_axi_wdata); exp_br = model_resp(s_axi_awaddr); exp_bv = 1'b1;
            end else if (s_axi_bready) begin
                exp_bv = 1'b0;
            end
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_final_readback();
        logic [31:0] d; logic [1:0] r; logic v, ok;
        for (int i = 0; i < 16; i++) begin
            axi_read(8'(4 * i), d, r, v, ok);
            checks++; if (!ok || d !== model[i] || r !== OKAY) begin errors++; $display("FAIL final_read[%0d] got %h exp %h", i, d, model[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_regs();
        test_out_of_range();
        test_backpressure();
        test_aw_wait();
        test_same_cycle_rw();
        test_reset_mid();
        test_random();
        test_final_readback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_reg_bridge.md
# axil_reg_bridge

AXI4-Lite slave exposing a bank of 32-bit read/write registers. It bridges a host AXI4-Lite master to local control/status storage. Writes are accepted as combined address+data beats and acknowledged on B. Reads return register contents on R with one-cycle latency. Single clock domain, no wait-state insertion beyond back-pressure.

## Interface
- ADDR_WIDTH, 8: byte address width of AW/AR.
- DATA_WIDTH, 32: register and bus data width; fixed at 32.
- NUM_REGS, 16: number of registers, word-aligned from byte address 0x00 (0x00..0x3C).

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); release synchronised externally.
- s_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address accepted.
- s_axi_wdata  in  32  write data; no byte strobes, full-word writes only.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data accepted.
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  master accepts response.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address accepted.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  master accepts read data.

## Operation
- Register index = addr[5:2]; addr[1:0] ignored. Address in range iff addr < 4*NUM_REGS (0x00..0x3C); otherwise out of range.
- Write channel: AW and W are accepted together only. awready = wready = awvalid & wvalid & (~bvalid | bready) (combinational). A lone AW or lone W is held off until its partner is valid.
- On write handshake edge: in-range → reg[index] <= wdata, bresp <= OKAY; out-of-range → no register change, bresp <= SLVERR. bvalid <= 1.
- bvalid clears on bvalid & bready edge unless a new write handshake occurs in the same cycle (then stays 1 with new bresp).
- Read channel: arready = ~rvalid | rready (combinational, independent of arvalid).
- On read handshake edge: rdata <= reg[index] (0 if out of range), rresp <= OKAY / SLVERR, rvalid <= 1.
- rvalid clears on rvalid & rready edge unless a new AR handshake occurs in the same edge (back-to-back reads, rvalid stays 1, rdata updates).
- rdata/rresp/bresp hold stable while the corresponding valid is high and ready is low.
- Read and write channels are fully independent; same-cycle read and write to the same register returns the pre-write value.

## Timing
- Reset (rst=0, asynchronous): all registers 0; bvalid=0, bresp=00, rvalid=0, rresp=00, rdata=0. Outputs awready/wready/arready follow their combinational equations (arready=1).
- Reset mid-transaction discards any pending B/R response; no partial register update.
- Write: handshake edge N → bvalid=1 after edge N; register value visible to a read handshaking at edge N+1 or later.
- Read: AR handshake edge N → rvalid/rdata valid after edge N (1-cycle latency).
- Throughput: one write and one read per cycle with ready held high by master.
- Back-pressure: bready=0 with bvalid=1 blocks further writes; rready=0 with rvalid=1 drops arready.

## Test plan
- Reset: rst=0 → bvalid=0, rvalid=0, rdata=0, arready=1; after release, read 0x00 → 0x00000000 OKAY.
- Write 0xDEADBEEF to 0x04 (awvalid,wvalid,bready=1 for 2 cycles) → bvalid=1, bresp=00; then arvalid=1, rready=1 at 0x04 for 2 cycles → rvalid=1, rdata=0xDEADBEEF after second edge.
- Write all 16 registers with 0x1000_0000+i, read back each → exact match, OKAY; addr low bits 0x05 alias to reg 1.
- Out-of-range write 0x40=0x12345678 → bresp=SLVERR, no register changes; read 0x80 → rdata=0, rresp=SLVERR.
- Back-pressure: bready=0 after a write → bvalid held, awready/wready=0 for next write until bready=1; rready=0 → rvalid, rdata stable, arready=0.
- AW valid without W for 3 cycles → no handshake; W arrives → both accepted same edge, bvalid next cycle.
